rs232_rxd: RTL and testbench
============================

// Module: rs232_rxd
// PURPOSE
//  8N1 asynchronous serial receiver; receive-side companion to the team's RS-232 transmitter.
//  Synchronises the raw RxD line, finds the start bit, samples 8 data bits (LSB first) and the stop bit,
//  then presents the byte on a valid/ready output held until consumed.
//  Flags framing errors and overruns. Sits between the board RX pin and the command/data consumer logic.
// PARAMETERS
//  CLKS_PER_BIT  1  clk cycles per serial bit (1 = one bit per clk, matching the transmitter); legal >=1
//  SYNC_STAGES   2  flops in the RxD input synchroniser; legal 1..3
// PORTS
//  clk        in   1  single clock; all logic on posedge
//  rst        in   1  asynchronous, active-high reset
//  RxD        in   1  serial line; idle high
//  RxD_data   out  8  received byte; valid while RxD_valid=1
//  RxD_valid  out  1  byte available; held until accepted
//  RxD_ready  in   1  consumer accepts byte when RxD_valid & RxD_ready on a posedge
//  frame_err  out  1  1-cycle pulse: stop bit sampled low
//  overrun    out  1  1-cycle pulse: completed byte dropped because output still occupied
//  busy       out  1  1 whenever FSM is not IDLE (combinational decode of state)
// BEHAVIOUR
//  Reset (async): RxD_data=0, RxD_valid=0, frame_err=0, overrun=0, FSM=IDLE (busy=0), sync flops=1, counters=0.
//   Reset mid-frame aborts the frame; no valid, no error flags for it.
//  rxs = RxD after SYNC_STAGES flops; pin change is visible on rxs SYNC_STAGES cycles later.
//  FSM states: IDLE, START, DATA, STOP, BREAK.
//   IDLE: t0 = first cycle rxs=0. Sample schedule: bit i (0=start, 1..8=d0..d7, 9=stop)
//    sampled from rxs at cycle t0 + (CLKS_PER_BIT-1)/2 + i*CLKS_PER_BIT (integer divide).
//    For CLKS_PER_BIT=1 the start sample is t0 itself.
//   START: start sample=1 -> glitch, return to IDLE, no outputs. =0 -> DATA.
//   DATA: 8 samples shifted in LSB first; bit counter 0..7; -> STOP after d7.
//   STOP: stop sample=1 -> byte complete, FSM to IDLE next cycle; a new start may be detected
//    the cycle after the stop sample (back-to-back frames with zero idle gap are legal).
//    stop sample=0 -> frame_err=1 for exactly one cycle, byte discarded, FSM to BREAK.
//   BREAK: stay until rxs=1, then IDLE (a held-low line yields one frame_err only).
//  Output handshake (byte complete at stop-sample cycle T; effects registered, visible T+1):
//   - output empty, or RxD_valid&RxD_ready at T: RxD_data<=byte, RxD_valid=1, overrun=0.
//   - RxD_valid=1 and RxD_ready=0 at T: old byte kept, new byte dropped, overrun=1 for one cycle.
//   - accept with no new byte: RxD_valid=0 next cycle; RxD_data keeps last value.
//  Latency: pin stop-bit start to RxD_valid high = SYNC_STAGES + (CLKS_PER_BIT-1)/2 + 1 cycles.
//  Bit-sample counter width = clog2(CLKS_PER_BIT) (min 1); wraps by reload, never free-runs.
//  frame_err and overrun never assert in the same cycle as each other.
// TESTING
//  1. Reset, drive transmitter (CLKS_PER_BIT=1) with 0xA5, ready=1 -> RxD_valid pulses once, RxD_data=0xA5, no flags.
//  2. Back-to-back 0x00 then 0xFF, zero idle gap, ready=1 -> two valids in order, data 0x00 then 0xFF.
//  3. CLKS_PER_BIT=16: one-clock low glitch on RxD -> FSM returns IDLE, no valid, no frame_err.
//  4. Frame 0x3C with stop bit forced 0, line held low 40 cycles -> one frame_err pulse, no valid, busy=1 until line high.
//  5. ready=0, send 0x11 then 0x22 -> RxD_data stays 0x11, overrun pulses once; ready=1 -> valid drops next cycle.
//  6. Assert rst during d3 of 0x5A, release, send 0xC3 -> outputs at reset values, then only 0xC3 delivered.

Source files
------------

// File: rtl/rs232_rxd.sv
// 8N1 asynchronous serial receiver: synchronises RxD, samples start/data/stop bits
// and presents each byte on a valid/ready output, flagging framing errors and overruns.
module rs232_rxd #(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_valid,
  input  logic       RxD_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'((HALF > 0) ? HALF - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   rxs;
  logic                   sample;
  logic                   byte_done;

  assign rxs    = sync_q[SYNC_STAGES-1];
  assign sample = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    byte_done = 1'b0;

    sync_d[0] = RxD;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end

    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          // With a zero half-bit offset the start sample is this very cycle.
          if (HALF == 0) begin
            state_d = S_DATA;
            cnt_d   = BIT_RELOAD;
            bit_d   = 3'd0;
          end else begin
            state_d = S_START;
            cnt_d   = HALF_RELOAD;
          end
        end
      end
      S_START: begin
        if (sample) begin
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = BIT_RELOAD;
            bit_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (sample) begin
          shift_d = {rxs, shift_q[7:1]};
          cnt_d   = BIT_RELOAD;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        if (sample) begin
          cnt_d = '0;
          if (rxs) begin
            byte_done = 1'b1;
            state_d   = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_BREAK: begin
        if (rxs) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // valid/ready: a byte transfers on any posedge where RxD_valid & RxD_ready.
    if (valid_q && RxD_ready) begin
      valid_d = 1'b0;
    end
    if (byte_done) begin
      if (!valid_q || RxD_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sync_q  <= '1;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign RxD_data  = data_q;
  assign RxD_valid = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_rs232_rxd.sv
// Bench for rs232_rxd: one receiver at one clock per bit, one at sixteen clocks per bit.
module tb_rs232_rxd;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd, ready;
  logic [7:0] rx_data;
  logic       rx_valid, ferr, ovr, busy;
  logic [2:0] state_dbg;
  logic       rxd16, ready16;
  logic [7:0] rx_data16;
  logic       rx_valid16, ferr16, ovr16, busy16;
  logic [2:0] state_dbg16;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp16_q[$];
  int acc_cnt = 0, ferr_cnt = 0, ovr_cnt = 0;
  int acc16_cnt = 0, ferr16_cnt = 0;
  bit busy16_seen = 1'b0;

  always #5 clk = ~clk;

  rs232_rxd #(.CLKS_PER_BIT(1), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .RxD(rxd), .RxD_data(rx_data), .RxD_valid(rx_valid),
    .RxD_ready(ready), .frame_err(ferr), .overrun(ovr), .busy(busy), .state_dbg(state_dbg)
  );

  rs232_rxd #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .rst(rst), .RxD(rxd16), .RxD_data(rx_data16), .RxD_valid(rx_valid16),
    .RxD_ready(ready16), .frame_err(ferr16), .overrun(ovr16), .busy(busy16), .state_dbg(state_dbg16)
  );

  // Scoreboard: every accepted byte is compared against the oldest expected byte.
  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (!rst) begin
      if (rx_valid && ready) begin
        acc_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %02h, expected queue empty", rx_data);
        end else begin
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            errors++;
            $display("FAIL byte_data: got %02h, expected %02h", rx_data, e);
          end
        end
      end
      if (rx_valid16 && ready16) begin
        acc16_cnt++;
        checks++;
        if (exp16_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte16: got %02h, expected queue empty", rx_data16);
        end else begin
          e = exp16_q.pop_front();
          if (rx_data16 !== e) begin
            errors++;
            $display("FAIL byte_data16: got %02h, expected %02h", rx_data16, e);
          end
        end
      end
      if (ferr) ferr_cnt++;
      if (ovr) ovr_cnt++;
      if (ferr16) ferr16_cnt++;
      if (busy16) busy16_seen = 1'b1;
      if (ferr && ovr) begin
        errors++;
        $display("FAIL flag_exclusive: frame_err=1 and overrun=1 in same cycle");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick();
    end
    rxd = stop_bit;
    tick();
  endtask

  task automatic send16(input logic [7:0] b);
    rxd16 = 1'b0;
    idle(16);
    for (int i = 0; i < 8; i++) begin
      rxd16 = b[i];
      idle(16);
    end
    rxd16 = 1'b1;
    idle(16);
  endtask

  task automatic test_reset();
    rst = 1'b1; rxd = 1'b1; ready = 1'b1; rxd16 = 1'b1; ready16 = 1'b1;
    idle(2);
    @(negedge clk);
    checks++;
    if ({rx_data, rx_valid, ferr, ovr, busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: data=%02h valid=%b ferr=%b ovr=%b busy=%b, expected all 0",
               rx_data, rx_valid, ferr, ovr, busy);
    end
    checks++;
    if ({rx_data16, rx_valid16, ferr16, ovr16, busy16} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs16: data=%02h valid=%b busy=%b, expected all 0",
               rx_data16, rx_valid16, busy16);
    end
    tick();
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_single_latency();
    logic [7:0] b;
    int a0, f0, o0;
    b = 8'hA5;
    a0 = acc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    exp_q.push_back(b);
    rxd = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick();
    end
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: valid=%b one cycle before expected, expected 0", rx_valid);
    end
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin
      errors++;
      $display("FAIL latency_on_time: valid=%b data=%02h, expected 1 / a5", rx_valid, rx_data);
    end
    idle(6);
    checks++;
    if (acc_cnt - a0 != 1 || ferr_cnt != f0 || ovr_cnt != o0) begin
      errors++;
      $display("FAIL single_a5: accepted=%0d ferr=%0d ovr=%0d, expected 1/0/0",
               acc_cnt - a0, ferr_cnt - f0, ovr_cnt - o0);
    end
  endtask

  task automatic test_back_to_back();
    int a0;
    a0 = acc_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(8);
    checks++;
    if (acc_cnt - a0 != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back: accepted=%0d pending=%0d, expected 2/0", acc_cnt - a0, exp_q.size());
    end
  endtask

  task automatic test_random_stream();
    int a0;
    logic [7:0] b;
    a0 = acc_cnt;
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_byte(b, 1'b1);
      idle($urandom_range(0, 3));
    end
    idle(8);
    checks++;
    if (acc_cnt - a0 != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_stream: accepted=%0d pending=%0d, expected 8/0", acc_cnt - a0, exp_q.size());
    end
  endtask

  task automatic test_glitch16();
    busy16_seen = 1'b0;
    rxd16 = 1'b0;
    tick();
    rxd16 = 1'b1;
    idle(40);
    checks++;
    if (busy16_seen !== 1'b1) begin
      errors++;
      $display("FAIL glitch16_detect: busy seen=%b, expected 1", busy16_seen);
    end
    checks++;
    if (busy16 !== 1'b0 || acc16_cnt != 0 || ferr16_cnt != 0) begin
      errors++;
      $display("FAIL glitch16_reject: busy=%b accepted=%0d ferr=%0d, expected 0/0/0",
               busy16, acc16_cnt, ferr16_cnt);
    end
  endtask

  task automatic test_frame16();
    exp16_q.push_back(8'h96);
    send16(8'h96);
    idle(20);
    checks++;
    if (acc16_cnt != 1 || exp16_q.size() != 0 || ferr16_cnt != 0) begin
      errors++;
      $display("FAIL frame16: accepted=%0d pending=%0d ferr=%0d, expected 1/0/0",
               acc16_cnt, exp16_q.size(), ferr16_cnt);
    end
  endtask

  task automatic test_frame_error();
    int a0, f0;
    a0 = acc_cnt; f0 = ferr_cnt;
    send_byte(8'h3C, 1'b0);
    idle(40);
    checks++;
    if (busy !== 1'b1 || state_dbg !== 3'd4) begin
      errors++;
      $display("FAIL break_hold: busy=%b state=%0d, expected 1/4", busy, state_dbg);
    end
    checks++;
    if (ferr_cnt - f0 != 1) begin
      errors++;
      $display("FAIL frame_err_pulse: frame_err cycles=%0d, expected 1", ferr_cnt - f0);
    end
    rxd = 1'b1;
    idle(5);
    checks++;
    if (busy !== 1'b0 || acc_cnt != a0 || ferr_cnt - f0 != 1) begin
      errors++;
      $display("FAIL break_exit: busy=%b accepted=%0d ferr=%0d, expected 0/0/1",
               busy, acc_cnt - a0, ferr_cnt - f0);
    end
  endtask

  task automatic test_overrun();
    int o0;
    o0 = ovr_cnt;
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle(5);
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      errors++;
      $display("FAIL overrun_hold: valid=%b data=%02h, expected 1/11", rx_valid, rx_data);
    end
    checks++;
    if (ovr_cnt - o0 != 1) begin
      errors++;
      $display("FAIL overrun_pulse: overrun cycles=%0d, expected 1", ovr_cnt - o0);
    end
    tick();
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h11 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL accept_drop: valid=%b data=%02h pending=%0d, expected 0/11/0",
               rx_valid, rx_data, exp_q.size());
    end
    idle(2);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int a0, f0;
    b = 8'h5A;
    a0 = acc_cnt; f0 = ferr_cnt;
    rxd = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      tick();
    end
    rst = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    checks++;
    if ({rx_data, rx_valid, ferr, ovr, busy} !== 12'h000) begin
      errors++;
      $display("FAIL mid_frame_reset: data=%02h valid=%b ferr=%b ovr=%b busy=%b, expected all 0",
               rx_data, rx_valid, ferr, ovr, busy);
    end
    tick();
    rst = 1'b0;
    idle(4);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3, 1'b1);
    idle(8);
    checks++;
    if (acc_cnt - a0 != 1 || exp_q.size() != 0 || ferr_cnt != f0) begin
      errors++;
      $display("FAIL after_reset_c3: accepted=%0d pending=%0d ferr=%0d, expected 1/0/0",
               acc_cnt - a0, exp_q.size(), ferr_cnt - f0);
    end
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_back_to_back();
    test_random_stream();
    test_glitch16();
    test_frame16();
    test_frame_error();
    test_overrun();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() != 0 || exp16_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d pending16=%0d, expected 0/0", exp_q.size(), exp16_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
